miriscv_data_ram: RTL

MIRISCV_DATA_RAM -- requirements
Module: miriscv_data_ram

---
 rtl/miriscv_pkg.sv | 21 ++
 rtl/miriscv_ram_array.sv | 27 ++
 rtl/miriscv_data_ram.sv | 136 +++++++++++++
 3 files changed

// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv memory subsystem: data-RAM controller
// state encoding and LSU access size codes.
package miriscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ram_state_e;

  typedef enum logic [2:0] {
    LSU_SB = 3'd0,
    LSU_SH = 3'd1,
    LSU_SW = 3'd2,
    LSU_UB = 3'd4,
    LSU_UH = 3'd5
  } lsu_size_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/miriscv_ram_array.sv
// Word-organised storage with byte-masked synchronous write and synchronous read.
// Contents are never reset; the read register only changes when re is high.
module miriscv_ram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        mask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/miriscv_data_ram.sv
// Data-RAM controller for the LSU: request latch, wait-state FSM, range check
// and registered response, wrapped around miriscv_ram_array.
module miriscv_data_ram
  import miriscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_mask_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int          ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;

  ram_state_e  state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        err_q;
  logic        data_zero;

  logic        we_q;
  logic [3:0]  mask_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        go_resp;
  logic        acc_we;
  logic [3:0]  acc_mask;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] offset;
  logic        in_range;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign accept  = (state == ST_IDLE) && mem_req_i;
  assign go_resp = (accept && (WAIT_STATES == 0)) ||
                   ((state == ST_WAIT) && (cnt == 4'd0));

  // With zero wait states the access completes on the accept edge itself,
  // so the live inputs are used instead of the not-yet-latched copies.
  always_comb begin
    acc_we    = we_q;
    acc_mask  = mask_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == ST_IDLE) begin
      acc_we    = mem_we_i;
      acc_mask  = mem_mask_i;
      acc_addr  = mem_addr_i;
      acc_wdata = mem_data_i;
    end
  end

  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign ram_we   = go_resp && acc_we && in_range && !reset;
  assign ram_re   = go_resp && !acc_we && in_range && !reset;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= mem_we_i;
      mask_q  <= mem_mask_i;
      addr_q  <= mem_addr_i;
      wdata_q <= mem_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      data_zero <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_req_i) begin
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // Response flags and the read-data select are registered on the edge
      // that enters RESP; writes leave the previous read word visible.
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= !in_range;
        if (!acc_we) data_zero <= !in_range;
      end
    end
  end

  miriscv_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .mask  (acc_mask),
    .addr  (offset[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign mem_data_o  = data_zero ? 32'h0 : ram_rdata;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;

endmodule
